// File: rtl/sdram_cfg_regfile.sv
// rtl/sdram_cfg_regfile.sv - per-bank SDRAM mode/timing register file with tMRD guard
// Optional readback port enabled by defining SDRAM_CFG_READBACK_EN.
module sdram_cfg_regfile #(
    parameter int NUM_BANKS    = 4,
    parameter int BANK_SEL_W   = 2,
    parameter int TIMING_WIDTH = 8,
    parameter int LAT_WIDTH    = 4,
    parameter int TMRD         = 2
) (
    input  logic                                  Clk,
    input  logic                                  Rst,
    input  logic                                  CS,
    input  logic                                  RAS,
    input  logic                                  CAS,
    input  logic                                  WeIn,
    input  logic [31:0]                           AddrIn,
    input  logic [BANK_SEL_W-1:0]                 BankSel,
    input  logic                                  MrsErrClr,
    input  logic                                  RdEn,
    input  logic [BANK_SEL_W-1:0]                 RdBank,
    output logic [NUM_BANKS*8-1:0]                TBurst,
    output logic [NUM_BANKS*3-1:0]                TBurstCfg,
    output logic [NUM_BANKS-1:0]                  AddrMode,
    output logic [LAT_WIDTH-1:0]                  TLat,
    output logic [TIMING_WIDTH-1:0]               TPre,
    output logic [TIMING_WIDTH-1:0]               TWait,
    output logic [TIMING_WIDTH-1:0]               TCas,
    output logic [NUM_BANKS*(TIMING_WIDTH+2)-1:0] TRas,
    output logic                                  Locked,
    output logic                                  Busy,
    output logic                                  MrsErr,
    output logic [31:0]                           RdData,
    output logic                                  RdValid
);

    localparam int TRAS_W = TIMING_WIDTH + 2;
    localparam int CNT_W  = $clog2(TMRD + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [NUM_BANKS-1:0][2:0]            cfg_q, cfg_d;
    logic [NUM_BANKS-1:0][7:0]            burst_q, burst_d;
    logic [NUM_BANKS-1:0]                 amode_q, amode_d;
    logic [LAT_WIDTH-1:0]                 lat_q, lat_d;
    logic [TIMING_WIDTH-1:0]              tpre_q, tpre_d;
    logic [TIMING_WIDTH-1:0]              twait_q, twait_d;
    logic [TIMING_WIDTH-1:0]              tcas_q, tcas_d;
    logic                                 locked_q, locked_d;
    logic                                 err_q, err_d;
    logic [NUM_BANKS-1:0][TRAS_W-1:0]     tras_q, tras_d;

    logic mrs;
    logic busy;
    logic accept;

    function automatic logic [7:0] burst_decode(input logic [2:0] code);
        if (code == 3'd7) begin
            burst_decode = 8'd255;
        end else begin
            burst_decode = 8'd1 << code;
        end
    endfunction

    assign mrs    = ~CS & ~RAS & ~CAS & ~WeIn;
    assign busy   = (state_q == ST_BUSY);
    assign accept = mrs & ~busy;

    // A command that arrives inside the window neither restarts nor extends it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d = ST_BUSY;
                cnt_d   = CNT_W'(TMRD);
            end
        end else begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        cfg_d    = cfg_q;
        burst_d  = burst_q;
        amode_d  = amode_q;
        lat_d    = lat_q;
        tpre_d   = tpre_q;
        twait_d  = twait_q;
        tcas_d   = tcas_q;
        locked_d = locked_q;
        err_d    = err_q;
        if (accept) begin
            cfg_d[BankSel]   = AddrIn[2:0];
            burst_d[BankSel] = burst_decode(AddrIn[2:0]);
            amode_d[BankSel] = AddrIn[3];
            if (!locked_q) begin
                lat_d    = AddrIn[4 +: LAT_WIDTH];
                tpre_d   = TIMING_WIDTH'(AddrIn[15:8]);
                twait_d  = TIMING_WIDTH'(AddrIn[23:16]);
                tcas_d   = TIMING_WIDTH'(AddrIn[31:24]);
                locked_d = 1'b1;
            end
        end
        if (mrs && busy) begin
            err_d = 1'b1;
        end else if (MrsErrClr) begin
            err_d = 1'b0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            tras_d[b] = TRAS_W'(tcas_q) + TRAS_W'(burst_q[b]) + TRAS_W'(twait_q);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cfg_q    <= '0;
            burst_q  <= {NUM_BANKS{8'd1}};
            amode_q  <= '0;
            lat_q    <= '0;
            tpre_q   <= '0;
            twait_q  <= '0;
            tcas_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            tras_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            burst_q  <= burst_d;
            amode_q  <= amode_d;
            lat_q    <= lat_d;
            tpre_q   <= tpre_d;
            twait_q  <= twait_d;
            tcas_q   <= tcas_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            tras_q   <= tras_d;
        end
    end

    assign TBurst    = burst_q;
    assign TBurstCfg = cfg_q;
    assign AddrMode  = amode_q;
    assign TLat      = lat_q;
    assign TPre      = tpre_q;
    assign TWait     = twait_q;
    assign TCas      = tcas_q;
    assign TRas      = tras_q;
    assign Locked    = locked_q;
    assign Busy      = busy;
    assign MrsErr    = err_q;

`ifdef SDRAM_CFG_READBACK_EN
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;

    // Sampled from pre-edge contents, so a read alongside an MRS sees the old values.
    always_comb begin
        rd_valid_d = RdEn;
        rd_data_d  = rd_data_q;
        if (RdEn) begin
            rd_data_d                = '0;
            rd_data_d[2:0]           = cfg_q[RdBank];
            rd_data_d[3]             = amode_q[RdBank];
            rd_data_d[4 +: LAT_WIDTH] = lat_q;
            rd_data_d[15:8]          = 8'(tpre_q);
            rd_data_d[23:16]         = 8'(twait_q);
            rd_data_d[31:24]         = 8'(tcas_q);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RdValid = rd_valid_q;
    assign RdData  = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd = ^{RdEn, RdBank};
    assign RdValid   = 1'b0;
    assign RdData    = '0;
`endif

endmodule
